lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one outstanding doubleword-lane memory access at a time.
// Handles byte/half/word/double loads and stores, lane shifting, byte masks,
// load sign/zero extension and misalignment detection.
module lsu #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_valid_i,
  input  logic [3:0]    lsu_op_i,
  input  logic [DW-1:0] lsu_addr_i,
  input  logic [DW-1:0] lsu_wdata_i,
  output logic          lsu_busy_o,
  output logic          lsu_done_o,
  output logic          lsu_misalign_o,
  output logic [DW-1:0] lsu_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [7:0]    mem_wmask_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  // Operation code fields: {store, unsigned, size[1:0]}
  localparam int unsigned OP_STORE = 3;
  localparam int unsigned OP_UNS   = 2;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          misalign_q, misalign_d;

  // Natural alignment check for the requested access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lo);
    logic ok;
    ok = 1'b1;
    unique case (size)
      2'd0: ok = 1'b1;
      2'd1: ok = (lo[0]   == 1'b0);
      2'd2: ok = (lo[1:0] == 2'b00);
      2'd3: ok = (lo[2:0] == 3'b000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Byte-enable pattern for a store of the given size at lane offset off.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    m = '0;
    unique case (size)
      2'd0: m = 8'h01 << off;
      2'd1: m = 8'h03 << off;
      2'd2: m = 8'h0F << off;
      2'd3: m = 8'hFF;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Extract the addressed lanes of a read doubleword and extend to full width.
  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] raw,
                                             input logic [2:0]    op,
                                             input logic [2:0]    off);
    logic [DW-1:0] shifted;
    logic [DW-1:0] res;
    logic          uns;
    shifted = raw >> {off, 3'b000};
    uns     = op[OP_UNS];
    res     = '0;
    unique case (op[1:0])
      2'd0: res = uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: res = uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: res = uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: res = shifted;
      default: res = shifted;
    endcase
    return res;
  endfunction

  // State and datapath registers; reset forces IDLE and clears all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack in REQ, single-cycle RESP.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          op_d    = lsu_op_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          if (is_aligned(lsu_op_i[1:0], lsu_addr_i[2:0])) begin
            state_d    = S_REQ;
            misalign_d = 1'b0;
          end else begin
            // Misaligned accesses never reach memory; report the error in RESP.
            state_d    = S_RESP;
            misalign_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ack_i) begin
          state_d = S_RESP;
          if (!op_q[OP_STORE]) begin
            rdata_d = load_ext(mem_rdata_i, op_q[2:0], addr_q[2:0]);
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    lsu_busy_o     = (state_q != S_IDLE);
    lsu_done_o     = (state_q == S_RESP);
    lsu_misalign_o = (state_q == S_RESP) && misalign_q;
    lsu_rdata_o    = rdata_q;
    mem_req_o      = (state_q == S_REQ);
    mem_we_o       = (state_q == S_REQ) && op_q[OP_STORE];
    mem_addr_o     = {addr_q[DW-1:3], 3'b000};
    mem_wdata_o    = wdata_q << {addr_q[2:0], 3'b000};
    mem_wmask_o    = ((state_q == S_REQ) && op_q[OP_STORE]) ?
                     lane_mask(op_q[1:0], addr_q[2:0]) : 8'h00;
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized operations
// checked against a byte-addressed memory model and spec-level lane rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i;
  logic [3:0]  lsu_op_i;
  logic [63:0] lsu_addr_i;
  logic [63:0] lsu_wdata_i;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic        lsu_misalign_o;
  logic [63:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_ack_i;
  logic [63:0] mem_rdata_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  mem [logic [63:0]];
  logic [63:0] exp_rdata = '0;

  lsu #(.DW(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_op_i       (lsu_op_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_busy_o     (lsu_busy_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wmask_o    (mem_wmask_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},     64'(lsu_busy_o),     64'd0);
    chk({tag, " done"},     64'(lsu_done_o),     64'd0);
    chk({tag, " misalign"}, 64'(lsu_misalign_o), 64'd0);
    chk({tag, " rdata"},    lsu_rdata_o,         64'd0);
    chk({tag, " req"},      64'(mem_req_o),      64'd0);
    chk({tag, " we"},       64'(mem_we_o),       64'd0);
    chk({tag, " addr"},     mem_addr_o,          64'd0);
    chk({tag, " wdata"},    mem_wdata_o,         64'd0);
    chk({tag, " wmask"},    64'(mem_wmask_o),    64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Memory model: byte store, lazily filled with random bytes on first read.
  task automatic model_word(input logic [63:0] base, output logic [63:0] w);
    w = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      logic [63:0] a;
      a = base + 64'(i);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      w[8*i +: 8] = mem[a];
    end
  endtask

  task automatic set_word(input logic [63:0] base, input logic [63:0] w);
    for (int unsigned i = 0; i < 8; i++) mem[base + 64'(i)] = w[8*i +: 8];
  endtask

  // Reference: gather n bytes starting at lane off, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [3:0] op,
                                           input logic [2:0] off);
    int unsigned n;
    logic [63:0] v;
    n = 1 << op[1:0];
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
    if (n < 8 && !op[2] && v[8*n-1]) begin
      for (int unsigned j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [7:0] ref_mask(input logic [3:0] op, input logic [2:0] off);
    int unsigned n;
    logic [7:0] m;
    n = 1 << op[1:0];
    m = '0;
    if (op[3]) begin
      for (int unsigned i = 0; i < n; i++) m[int'(off) + i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i >= off) r[8*i +: 8] = wd[8*(i - off) +: 8];
    end
    return r;
  endfunction

  // One complete transaction: start, hold ack off for 'waits' cycles, then ack.
  task automatic do_op(input logic [3:0] op, input logic [63:0] addr,
                       input logic [63:0] wdata, input int unsigned waits);
    int unsigned n;
    logic [2:0]  off;
    logic        aligned;
    logic [63:0] base, word, ewd;
    logic [7:0]  emask;
    n       = 1 << op[1:0];
    off     = addr[2:0];
    aligned = (addr % 64'(n)) == 0;
    base    = {addr[63:3], 3'b000};
    emask   = ref_mask(op, off);
    ewd     = ref_wdata(wdata, off);
    word    = '0;

    @(negedge clk);
    lsu_valid_i = 1'b1; lsu_op_i = op; lsu_addr_i = addr; lsu_wdata_i = wdata; mem_ack_i = 1'b0;
    @(negedge clk);
    lsu_valid_i = 1'b0; lsu_op_i = 4'($urandom); lsu_addr_i = rnd64(); lsu_wdata_i = rnd64();
    chk("busy after start", 64'(lsu_busy_o), 64'd1);

    if (!aligned) begin
      chk("misal req",      64'(mem_req_o),      64'd0);
      chk("misal done",     64'(lsu_done_o),     64'd1);
      chk("misal flag",     64'(lsu_misalign_o), 64'd1);
      chk("misal rdata",    lsu_rdata_o,         exp_rdata);
      mem_ack_i = 1'($urandom);
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("misal idle busy", 64'(lsu_busy_o),     64'd0);
      chk("misal idle done", 64'(lsu_done_o),     64'd0);
      chk("misal idle flag", 64'(lsu_misalign_o), 64'd0);
      chk("misal idle req",  64'(mem_req_o),      64'd0);
      return;
    end

    for (int unsigned w = 0; w <= waits; w++) begin
      chk("req",   64'(mem_req_o),   64'd1);
      chk("we",    64'(mem_we_o),    64'(op[3]));
      chk("addr",  mem_addr_o,       base);
      chk("wmask", 64'(mem_wmask_o), 64'(emask));
      chk("wdata", mem_wdata_o,      ewd);
      chk("done early", 64'(lsu_done_o), 64'd0);
      if (w == waits) begin
        model_word(base, word);
        mem_rdata_i = word; mem_ack_i = 1'b1; lsu_valid_i = 1'b0;
      end else begin
        mem_rdata_i = rnd64(); mem_ack_i = 1'b0;
        lsu_valid_i = 1'($urandom); lsu_op_i = 4'($urandom);
        lsu_addr_i = rnd64(); lsu_wdata_i = rnd64();
      end
      @(negedge clk);
    end

    mem_ack_i = 1'($urandom); mem_rdata_i = rnd64(); lsu_valid_i = 1'b0;
    if (op[3]) begin
      for (int unsigned i = 0; i < 8; i++) if (emask[i]) mem[base + 64'(i)] = ewd[8*i +: 8];
    end else begin
      exp_rdata = ref_load(word, op, off);
    end
    chk("resp done",     64'(lsu_done_o),     64'd1);
    chk("resp misalign", 64'(lsu_misalign_o), 64'd0);
    chk("resp req",      64'(mem_req_o),      64'd0);
    chk("resp rdata",    lsu_rdata_o,         exp_rdata);
    @(negedge clk);
    mem_ack_i = 1'($urandom);
    chk("idle busy", 64'(lsu_busy_o), 64'd0);
    chk("idle done", 64'(lsu_done_o), 64'd0);
    chk("idle req",  64'(mem_req_o),  64'd0);
  endtask

  initial begin
    logic [63:0] w, a, sdata;
    logic [3:0]  op;
    rst = 1'b1; lsu_valid_i = 1'b1; lsu_op_i = 4'b0011; lsu_addr_i = 64'h100;
    lsu_wdata_i = '0; mem_ack_i = 1'b1; mem_rdata_i = '0;

    // Reset holds everything at zero even with stimulus present.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    lsu_valid_i = 1'b0; mem_ack_i = 1'b0;
    rst = 1'b0;

    // LB sign-extended from lane 5.
    set_word(64'h8000_0000, 64'h0000_8000_0000_0000);
    do_op(4'b0000, 64'h8000_0005, rnd64(), 1);
    chk("LB result", lsu_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);

    // LHU from lanes 7:6.
    set_word(64'h2000, 64'hBEEF_1234_5678_9ABC);
    do_op(4'b0101, 64'h2006, rnd64(), 0);
    chk("LHU result", lsu_rdata_o, 64'h0000_0000_0000_BEEF);

    // SW to upper half with three wait cycles.
    do_op(4'b1010, 64'h1004, 64'h0000_0000_1122_3344, 3);

    // Misaligned LW.
    do_op(4'b0010, 64'h1002, rnd64(), 0);

    // Reset during REQ: req drops without a clock edge, later ack ignored.
    @(negedge clk);
    lsu_valid_i = 1'b1; lsu_op_i = 4'b0011; lsu_addr_i = 64'h3000; mem_ack_i = 1'b0;
    @(negedge clk);
    lsu_valid_i = 1'b0;
    chk("pre-rst req", 64'(mem_req_o), 64'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async rst");
    @(negedge clk);
    rst = 1'b0; exp_rdata = '0;
    mem_ack_i = 1'b1; mem_rdata_i = rnd64();
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk_all_zero("post-rst ack");
    @(negedge clk);
    chk("post-rst done", 64'(lsu_done_o), 64'd0);

    // Back-to-back SD then LD with valid held high.
    a = 64'h4000_0040; sdata = rnd64();
    @(negedge clk);
    lsu_valid_i = 1'b1; lsu_op_i = 4'b1011; lsu_addr_i = a; lsu_wdata_i = sdata;
    @(negedge clk);
    lsu_op_i = 4'b0011; lsu_wdata_i = rnd64();
    chk("b2b SD we",    64'(mem_we_o),    64'd1);
    chk("b2b SD mask",  64'(mem_wmask_o), 64'hFF);
    chk("b2b SD wdata", mem_wdata_o,      sdata);
    mem_ack_i = 1'b1; mem_rdata_i = rnd64();
    @(negedge clk);
    mem_ack_i = 1'b0;
    set_word(a, sdata);
    chk("b2b SD done", 64'(lsu_done_o), 64'd1);
    @(negedge clk);
    chk("b2b gap busy", 64'(lsu_busy_o), 64'd0);
    @(negedge clk);
    lsu_valid_i = 1'b0;
    chk("b2b LD req",  64'(mem_req_o), 64'd1);
    chk("b2b LD we",   64'(mem_we_o),  64'd0);
    chk("b2b LD addr", mem_addr_o,     a);
    model_word(a, w);
    mem_rdata_i = w; mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    exp_rdata = sdata;
    chk("b2b LD done",  64'(lsu_done_o), 64'd1);
    chk("b2b LD rdata", lsu_rdata_o,     sdata);
    @(negedge clk);
    chk("b2b idle", 64'(lsu_busy_o), 64'd0);

    // Randomized mix over a small address window.
    for (int k = 0; k < 250; k++) begin
      op = 4'($urandom);
      a  = 64'h4000_0000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) a = a & ~(64'(1 << op[1:0]) - 64'd1);
      do_op(op, a, rnd64(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
